weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader_pkg.sv | 18 +
 rtl/weight_loader.sv | 104 ++++++++++
 tb/tb_weight_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight-loading path: channel count, ROM geometry,
// the packed weight-line type and the loader state encoding.
package weight_loader_pkg;

    localparam int K_CHANNELS        = 6;
    localparam int ROM_WEIGHTS_WIDTH = 8;
    localparam int ROM_WEIGHTS_DEPTH = 64;
    localparam int LANE_W            = (K_CHANNELS > 1) ? $clog2(K_CHANNELS) : 1;

    typedef logic [K_CHANNELS-1:0][ROM_WEIGHTS_WIDTH-1:0] weight_line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/weight_loader.sv
// Packs a byte stream into K_CHANNELS-wide lines and writes DEPTH lines to an external weight memory.
// Latency: a line is written the cycle after its last byte is accepted; done_o follows one cycle later.
// Backpressure: s_ready_o is high for the whole LOAD state only; bubbles on s_valid_i simply stall packing.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int WIDTH   = ROM_WEIGHTS_WIDTH,
    parameter int DEPTH   = ROM_WEIGHTS_DEPTH,
    parameter int DEPTH_W = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [WIDTH-1:0]              s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic                          wr_en_o,
    output logic [DEPTH_W-1:0]            wr_addr_o,
    output logic [K_CHANNELS*WIDTH-1:0]   wr_data_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          loaded_o
);

    loader_state_t                      state;
    logic [LANE_W-1:0]                  lane_cnt;
    logic [DEPTH_W-1:0]                 addr_cnt;
    logic [K_CHANNELS-1:0][WIDTH-1:0]   line_q;
    logic [K_CHANNELS-1:0][WIDTH-1:0]   next_line;
    logic                               lane_last;
    logic                               addr_last;

    assign s_ready_o = (state == LOAD);
    assign busy_o    = (state == LOAD);
    assign lane_last = (lane_cnt == LANE_W'(K_CHANNELS - 1));
    assign addr_last = (addr_cnt == DEPTH_W'(DEPTH - 1));

    // Current line with the incoming byte dropped into the lane being filled.
    always_comb begin
        next_line = line_q;
        for (int k = 0; k < K_CHANNELS; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                next_line[k] = s_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lane_cnt  <= '0;
            addr_cnt  <= '0;
            line_q    <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            done_o    <= 1'b0;
            loaded_o  <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= LOAD;
                        lane_cnt <= '0;
                        addr_cnt <= '0;
                        loaded_o <= 1'b0;
                    end
                end
                LOAD: begin
                    // Abort beats a byte arriving in the same cycle; the partial line is dropped.
                    if (abort_i) begin
                        state    <= IDLE;
                        lane_cnt <= '0;
                    end else if (s_valid_i) begin
                        if (lane_last) begin
                            lane_cnt  <= '0;
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= addr_cnt;
                            wr_data_o <= next_line;
                            if (addr_last) begin
                                state <= DONE;
                            end else begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end else begin
                            line_q   <= next_line;
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done_o   <= 1'b1;
                    loaded_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Randomised self-checking bench for weight_loader with K_CHANNELS=6, DEPTH=4.
module tb_weight_loader;

    localparam int K  = 6;
    localparam int D  = 4;
    localparam int W  = 8;
    localparam int NB = K * D;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic            abort_i = 1'b0;
    logic [W-1:0]    s_data_i = '0;
    logic            s_valid_i = 1'b0;
    logic            s_ready_o;
    logic            wr_en_o;
    logic [1:0]      wr_addr_o;
    logic [K*W-1:0]  wr_data_o;
    logic            busy_o;
    logic            done_o;
    logic            loaded_o;

    weight_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .loaded_o  (loaded_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   stim[$];
    int             wa_q[$];
    logic [K*W-1:0] wd_q[$];
    int             done_cnt = 0;
    int             ready_low = 0;

    always @(negedge clk_i) begin
        if (wr_en_o === 1'b1) begin
            wa_q.push_back(int'(wr_addr_o));
            wd_q.push_back(wr_data_o);
        end
        if (done_o === 1'b1) done_cnt++;
    end

    // Reference: line j is bytes 6j..6j+5 with the first byte in the least significant lane.
    function automatic logic [K*W-1:0] exp_line(input int j);
        logic [K*W-1:0] v;
        v = '0;
        for (int k = 0; k < K; k++) v = v + ((K*W)'(stim[j*K + k]) << (W*k));
        return v;
    endfunction

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        done_cnt  = 0;
        ready_low = 0;
    endtask

    task automatic fill_random();
        stim.delete();
        for (int i = 0; i < NB; i++) stim.push_back(W'($urandom_range(0, 255)));
    endtask

    task automatic pulse_start();
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random bubbles.
    task automatic feed(input int mode, input int n, input bit restart);
        int idx = 0;
        int cyc = 0;
        bit slot;
        while (idx < n && cyc < 1000) begin
            if (cyc > 0) @(negedge clk_i);
            cyc++;
            slot = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 2) != 0);
            s_valid_i = slot;
            s_data_i  = stim[idx];
            start_i   = restart && (cyc % 7 == 3);
            if (s_ready_o !== 1'b1) ready_low++;
            else if (slot) idx++;
        end
        if (idx < n) begin
            errors++;
            $display("FAIL feed_timeout accepted %0d required %0d", idx, n);
        end
        @(negedge clk_i);
        s_valid_i = 1'b0;
        start_i   = 1'b0;
    endtask

    task automatic wait_done();
        int c = 0;
        while (done_cnt == 0 && c < 20) begin
            @(negedge clk_i);
            c++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout got no done_o pulse required one");
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++; if (wr_en_o !== 1'b0)   begin errors++; $display("FAIL rst_wr_en got %b req 0", wr_en_o); end
        checks++; if (wr_addr_o !== 2'd0) begin errors++; $display("FAIL rst_wr_addr got %0d req 0", wr_addr_o); end
        checks++; if (wr_data_o !== '0)   begin errors++; $display("FAIL rst_wr_data got %h req 0", wr_data_o); end
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b req 0", s_ready_o); end
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b req 0", busy_o); end
        checks++; if (done_o !== 1'b0)    begin errors++; $display("FAIL rst_done got %b req 0", done_o); end
        checks++; if (loaded_o !== 1'b0)  begin errors++; $display("FAIL rst_loaded got %b req 0", loaded_o); end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL idle_s_ready got %b req 0", s_ready_o); end
    endtask

    task automatic check_full_load(input string tag);
        checks++;
        if (wa_q.size() != D) begin
            errors++; $display("FAIL %s_write_count got %0d req %0d", tag, wa_q.size(), D);
        end else begin
            for (int j = 0; j < D; j++) begin
                checks++;
                if (wa_q[j] != j || wd_q[j] !== exp_line(j)) begin
                    errors++;
                    $display("FAIL %s_line%0d got addr %0d data %h req addr %0d data %h",
                             tag, j, wa_q[j], wd_q[j], j, exp_line(j));
                end
            end
        end
        checks++; if (done_cnt != 1)     begin errors++; $display("FAIL %s_done_pulses got %0d req 1", tag, done_cnt); end
        checks++; if (loaded_o !== 1'b1) begin errors++; $display("FAIL %s_loaded got %b req 1", tag, loaded_o); end
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL %s_busy got %b req 0", tag, busy_o); end
        checks++;
        if (wr_data_o !== exp_line(D-1)) begin
            errors++; $display("FAIL %s_data_hold got %h req %h", tag, wr_data_o, exp_line(D-1));
        end
    endtask

    task automatic test_back_to_back();
        int nw;
        stim.delete();
        for (int i = 1; i <= NB; i++) stim.push_back(W'(i));
        clear_obs();
        pulse_start();
        feed(0, NB, 1'b0);
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_last got %b req 0", s_ready_o); end
        wait_done();
        check_full_load("b2b");
        checks++;
        if (wd_q.size() > 0 && wd_q[0] !== 48'h060504030201) begin
            errors++; $display("FAIL b2b_addr0_const got %h req 060504030201", wd_q[0]);
        end
        // Keep pushing after completion: nothing may be accepted or written.
        nw = wa_q.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            s_valid_i = 1'b1;
            s_data_i  = W'($urandom_range(0, 255));
            if (s_ready_o !== 1'b0) ready_low++;
        end
        @(negedge clk_i); s_valid_i = 1'b0;
        checks++; if (ready_low != 0)     begin errors++; $display("FAIL overfeed_ready got %0d ready cycles req 0", ready_low); end
        checks++; if (wa_q.size() != nw)  begin errors++; $display("FAIL overfeed_writes got %0d req %0d", wa_q.size(), nw); end
    endtask

    task automatic test_bubbles();
        fill_random();
        clear_obs();
        pulse_start();
        feed(1, NB, 1'b0);
        wait_done();
        checks++; if (ready_low != 0) begin errors++; $display("FAIL bubble_ready_drops got %0d req 0", ready_low); end
        check_full_load("bubble");
    endtask

    task automatic test_abort();
        fill_random();
        clear_obs();
        pulse_start();
        checks++; if (loaded_o !== 1'b0) begin errors++; $display("FAIL abort_loaded_drop got %b req 0", loaded_o); end
        feed(0, 9, 1'b0);
        abort_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = W'($urandom_range(0, 255));
        @(negedge clk_i);
        abort_i   = 1'b0;
        s_valid_i = 1'b0;
        repeat (8) @(negedge clk_i);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] != 0 || wd_q[0] !== exp_line(0)) begin
            errors++; $display("FAIL abort_writes got %0d writes req 1 at addr 0", wa_q.size());
        end
        checks++; if (done_cnt != 0)      begin errors++; $display("FAIL abort_done got %0d req 0", done_cnt); end
        checks++; if (loaded_o !== 1'b0)  begin errors++; $display("FAIL abort_loaded got %b req 0", loaded_o); end
        checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready got %b req 0", s_ready_o); end
        fill_random();
        clear_obs();
        pulse_start();
        feed(2, NB, 1'b0);
        wait_done();
        check_full_load("reload");
    endtask

    task automatic test_reset_mid_load();
        fill_random();
        clear_obs();
        pulse_start();
        feed(0, 15, 1'b0);
        s_valid_i = 1'b1;
        rst_i     = 1'b1;
        #1;
        checks++;
        if ({wr_en_o, wr_addr_o, wr_data_o, s_ready_o, busy_o, done_o, loaded_o} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got en%b addr%0d data%h rdy%b busy%b done%b ld%b req all 0",
                     wr_en_o, wr_addr_o, wr_data_o, s_ready_o, busy_o, done_o, loaded_o);
        end
        @(negedge clk_i);
        clear_obs();
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            s_data_i = W'($urandom_range(0, 255));
        end
        s_valid_i = 1'b0;
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL midrst_writes got %0d req 0", wa_q.size()); end
        checks++; if (done_cnt != 0)    begin errors++; $display("FAIL midrst_done got %0d req 0", done_cnt); end
    endtask

    task automatic test_restart_ignored();
        fill_random();
        clear_obs();
        pulse_start();
        feed(2, NB, 1'b1);
        wait_done();
        check_full_load("restart");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_abort();
        test_reset_mid_load();
        test_restart_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
